// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Tracks score, combo, multiplier and health for one play session. Event inputs
// come from the state processor once per cycle. Outputs go to the HUD renderer
// and the game-flow controller.
//
// Slices and misses are deduplicated against the index of the last block
// consumed. Obstacle hits are rate-limited by a cooldown counter. All outputs
// are registered, so an event sampled on edge N shows up right after edge N.
//
// Ports
//   clk_in                  system clock
//   rst_in                  asynchronous, active-high reset
//   state                   game state: 0 menu, 1 playing, 2 paused, 3 paused
//   curr_block_index_in     block index that the slice/miss inputs refer to
//   block_sliced            slice event this cycle
//   player_hit_by_obstacle  obstacle contact this cycle
//   block_missed            miss event this cycle
//   score                   accumulated score, saturating at 2^20-1
//   combo                   consecutive slices, saturating at 1023
//   multiplier              1..MAX_MULT, derived from combo
//   health                  0..MAX_HEALTH
//   game_over               high while the session is in the OVER state
//   score_event             one-cycle pulse for each scored slice
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int MAX_HEALTH        = 100,
    parameter int SLICE_POINTS      = 100,
    parameter int HEAL_AMOUNT       = 2,
    parameter int MISS_DAMAGE       = 10,
    parameter int OBSTACLE_DAMAGE   = 15,
    parameter int MULT_STEP         = 8,
    parameter int MAX_MULT          = 8,
    parameter int OBSTACLE_COOLDOWN = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  state,
    input  logic [7:0]  curr_block_index_in,
    input  logic        block_sliced,
    input  logic        player_hit_by_obstacle,
    input  logic        block_missed,
    output logic [19:0] score,
    output logic [9:0]  combo,
    output logic [3:0]  multiplier,
    output logic [7:0]  health,
    output logic        game_over,
    output logic        score_event
);

    // MULT_STEP is a power of two, so dividing combo by it is a right shift.
    localparam int               MULT_SHIFT  = $clog2(MULT_STEP);
    localparam logic [19:0]      SCORE_MAX   = 20'hF_FFFF;
    localparam logic [9:0]       COMBO_MAX   = 10'h3FF;
    localparam logic [7:0]       HEALTH_FULL = 8'(MAX_HEALTH);
    localparam logic [7:0]       CD_LOAD     = 8'(OBSTACLE_COOLDOWN);
    localparam logic [3:0]       MULT_CAP    = 4'(MAX_MULT);
    localparam logic [20:0]      SLICE_PTS   = 21'(SLICE_POINTS);
    localparam logic signed [9:0] HEAL_S     = 10'(HEAL_AMOUNT);
    localparam logic signed [9:0] MISS_S     = 10'(MISS_DAMAGE);
    localparam logic signed [9:0] OBS_S      = 10'(OBSTACLE_DAMAGE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [19:0]        score_q, score_d;
    logic [9:0]         combo_q, combo_d;
    logic [3:0]         mult_q, mult_d;
    logic [7:0]         health_q, health_d;
    logic               game_over_q, game_over_d;
    logic               score_event_q, score_event_d;
    logic [7:0]         cooldown_q, cooldown_d;
    logic [7:0]         last_index_q, last_index_d;
    logic               last_valid_q, last_valid_d;

    logic               play_active_s;
    logic               idx_new_s;
    logic               slice_acc_s;
    logic               miss_acc_s;
    logic               obs_acc_s;
    logic [20:0]        score_sum_s;
    logic [19:0]        score_sat_s;
    logic [9:0]         combo_inc_s;
    logic signed [9:0]  health_sum_s;

    // Multiplier level for a given combo: 1 + combo/MULT_STEP, capped.
    function automatic logic [3:0] mult_for_combo(input logic [9:0] c);
        logic [9:0] lvl;
        lvl = (c >> MULT_SHIFT) + 10'd1;
        if (lvl > {6'd0, MULT_CAP}) begin
            return MULT_CAP;
        end else begin
            return lvl[3:0];
        end
    endfunction

    // Clamp a signed health sum into 0..MAX_HEALTH.
    function automatic logic [7:0] clamp_health(input logic signed [9:0] h);
        if (h < 10'sd0) begin
            return 8'd0;
        end else if (h > $signed({2'b00, HEALTH_FULL})) begin
            return HEALTH_FULL;
        end else begin
            return h[7:0];
        end
    endfunction

    // Events only count while the session is running and not paused.
    assign play_active_s = (fsm_q == S_PLAY) && (state == 2'd1);

    // A block index is consumed once. The first event after a session starts
    // is always new because last_valid is cleared on session entry.
    assign idx_new_s = !last_valid_q || (curr_block_index_in != last_index_q);

    // A slice beats a miss on the same cycle, so the miss is masked by
    // block_sliced itself, even when the slice is a duplicate.
    assign slice_acc_s = play_active_s && block_sliced && idx_new_s;
    assign miss_acc_s  = play_active_s && block_missed && !block_sliced && idx_new_s;
    assign obs_acc_s   = play_active_s && player_hit_by_obstacle && (cooldown_q == 8'd0);

    // Score uses the multiplier held before this cycle's update.
    assign score_sum_s = {1'b0, score_q} + (SLICE_PTS * {17'd0, mult_q});
    assign score_sat_s = score_sum_s[20] ? SCORE_MAX : score_sum_s[19:0];
    assign combo_inc_s = (combo_q == COMBO_MAX) ? COMBO_MAX : (combo_q + 10'd1);

    // Heal and every kind of damage land as a single signed sum, clamped once.
    assign health_sum_s = $signed({2'b00, health_q})
                        + (slice_acc_s ? HEAL_S : 10'sd0)
                        - (miss_acc_s  ? MISS_S : 10'sd0)
                        - (obs_acc_s   ? OBS_S  : 10'sd0);

    // Next-state and next-value logic for the session FSM and all counters.
    always_comb begin
        fsm_d         = fsm_q;
        score_d       = score_q;
        combo_d       = combo_q;
        mult_d        = mult_q;
        health_d      = health_q;
        score_event_d = 1'b0;
        cooldown_d    = cooldown_q;
        last_index_d  = last_index_q;
        last_valid_d  = last_valid_q;

        case (fsm_q)
            S_IDLE: begin
                if (state == 2'd1) begin
                    // Starting a session wipes the previous one.
                    fsm_d        = S_PLAY;
                    score_d      = 20'd0;
                    combo_d      = 10'd0;
                    mult_d       = 4'd1;
                    health_d     = HEALTH_FULL;
                    cooldown_d   = 8'd0;
                    last_valid_d = 1'b0;
                end else begin
                    fsm_d = S_IDLE;
                end
            end

            S_PLAY: begin
                if (state == 2'd0) begin
                    // Leave to the menu and keep the values for the HUD.
                    fsm_d = S_IDLE;
                end else if (play_active_s) begin
                    if (slice_acc_s) begin
                        score_d       = score_sat_s;
                        score_event_d = 1'b1;
                    end else begin
                        score_d = score_q;
                    end

                    if (slice_acc_s || miss_acc_s) begin
                        last_index_d = curr_block_index_in;
                        last_valid_d = 1'b1;
                    end else begin
                        last_index_d = last_index_q;
                        last_valid_d = last_valid_q;
                    end

                    // Any damage breaks the combo, even alongside a slice.
                    if (obs_acc_s || miss_acc_s) begin
                        combo_d = 10'd0;
                    end else if (slice_acc_s) begin
                        combo_d = combo_inc_s;
                    end else begin
                        combo_d = combo_q;
                    end
                    mult_d   = mult_for_combo(combo_d);
                    health_d = clamp_health(health_sum_s);

                    if (obs_acc_s) begin
                        cooldown_d = CD_LOAD;
                    end else if (cooldown_q != 8'd0) begin
                        cooldown_d = cooldown_q - 8'd1;
                    end else begin
                        cooldown_d = cooldown_q;
                    end

                    // Enter OVER on the same edge that drains the last health.
                    if (health_d == 8'd0) begin
                        fsm_d = S_OVER;
                    end else begin
                        fsm_d = S_PLAY;
                    end
                end else begin
                    // Paused: everything, including the cooldown, is frozen.
                    fsm_d = S_PLAY;
                end
            end

            S_OVER: begin
                if (state == 2'd0) begin
                    fsm_d = S_IDLE;
                end else begin
                    fsm_d = S_OVER;
                end
            end

            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        game_over_d = (fsm_d == S_OVER);
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fsm_q         <= S_IDLE;
            score_q       <= 20'd0;
            combo_q       <= 10'd0;
            mult_q        <= 4'd1;
            health_q      <= HEALTH_FULL;
            game_over_q   <= 1'b0;
            score_event_q <= 1'b0;
            cooldown_q    <= 8'd0;
            last_index_q  <= 8'd0;
            last_valid_q  <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            mult_q        <= mult_d;
            health_q      <= health_d;
            game_over_q   <= game_over_d;
            score_event_q <= score_event_d;
            cooldown_q    <= cooldown_d;
            last_index_q  <= last_index_d;
            last_valid_q  <= last_valid_d;
        end
    end

    assign score       = score_q;
    assign combo       = combo_q;
    assign multiplier  = mult_q;
    assign health      = health_q;
    assign game_over   = game_over_q;
    assign score_event = score_event_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: one linear stimulus sequence with
// hand-computed expectations, sampled 1 ns after each rising edge.
module tb_score_keeper;

    logic        clk_in;
    logic        rst_in;
    logic [1:0]  state;
    logic [7:0]  curr_block_index_in;
    logic        block_sliced;
    logic        player_hit_by_obstacle;
    logic        block_missed;
    logic [19:0] score;
    logic [9:0]  combo;
    logic [3:0]  multiplier;
    logic [7:0]  health;
    logic        game_over;
    logic        score_event;

    int n_assert;
    int n_fail;
    int pulses;

    score_keeper dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .state                  (state),
        .curr_block_index_in    (curr_block_index_in),
        .block_sliced           (block_sliced),
        .player_hit_by_obstacle (player_hit_by_obstacle),
        .block_missed           (block_missed),
        .score                  (score),
        .combo                  (combo),
        .multiplier             (multiplier),
        .health                 (health),
        .game_over              (game_over),
        .score_event            (score_event)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Restart a session from a clean slate: menu for one cycle, then play.
    task automatic new_session();
        block_sliced = 1'b0;
        block_missed = 1'b0;
        player_hit_by_obstacle = 1'b0;
        state = 2'd0;
        tick();
        state = 2'd1;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst_in = 1'b1;
        state = 2'd0;
        curr_block_index_in = 8'd0;
        block_sliced = 1'b0;
        player_hit_by_obstacle = 1'b0;
        block_missed = 1'b0;
        ticks(2);

        // Reset values
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_mult", 32'(multiplier), 32'd1);
        chk("rst_health", 32'(health), 32'd100);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_score_event", 32'(score_event), 32'd0);
        rst_in = 1'b0;

        // Nine slices on distinct indices; multiplier steps to 2 after the 8th
        state = 2'd1;
        tick();
        pulses = 0;
        block_sliced = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            curr_block_index_in = 8'(i);
            tick();
            if (score_event === 1'b1) pulses++;
            if (i == 8) begin
                chk("s8_score", 32'(score), 32'd800);
                chk("s8_combo", 32'(combo), 32'd8);
                chk("s8_mult", 32'(multiplier), 32'd2);
            end
        end
        block_sliced = 1'b0;
        chk("s9_score", 32'(score), 32'd1000);
        chk("s9_combo", 32'(combo), 32'd9);
        chk("s9_mult", 32'(multiplier), 32'd2);
        chk("s9_pulses", 32'(pulses), 32'd9);
        tick();
        chk("s9_event_drop", 32'(score_event), 32'd0);

        // Same index held for four cycles counts once
        new_session();
        chk("sess_score_clr", 32'(score), 32'd0);
        chk("sess_combo_clr", 32'(combo), 32'd0);
        curr_block_index_in = 8'd5;
        block_sliced = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (score_event === 1'b1) pulses++;
        end
        chk("dup_score", 32'(score), 32'd100);
        chk("dup_combo", 32'(combo), 32'd1);
        chk("dup_pulses", 32'(pulses), 32'd1);

        // Build combo to 7, then a miss resets it; repeating the miss is ignored
        for (int i = 6; i <= 11; i++) begin
            curr_block_index_in = 8'(i);
            tick();
        end
        block_sliced = 1'b0;
        chk("c7_combo", 32'(combo), 32'd7);
        chk("c7_score", 32'(score), 32'd700);
        chk("c7_health_cap", 32'(health), 32'd100);
        curr_block_index_in = 8'd20;
        block_missed = 1'b1;
        tick();
        chk("miss_combo", 32'(combo), 32'd0);
        chk("miss_mult", 32'(multiplier), 32'd1);
        chk("miss_health", 32'(health), 32'd90);
        tick();
        chk("miss_dup_health", 32'(health), 32'd90);
        chk("miss_dup_combo", 32'(combo), 32'd0);
        // Slice and miss together: slice wins
        curr_block_index_in = 8'd21;
        block_sliced = 1'b1;
        tick();
        block_sliced = 1'b0;
        block_missed = 1'b0;
        chk("slmiss_combo", 32'(combo), 32'd1);
        chk("slmiss_health", 32'(health), 32'd92);
        chk("slmiss_score", 32'(score), 32'd800);
        chk("slmiss_event", 32'(score_event), 32'd1);

        // Obstacle held for 100 cycles: two hits land
        new_session();
        player_hit_by_obstacle = 1'b1;
        tick();
        chk("obs_first_health", 32'(health), 32'd85);
        ticks(29);
        chk("obs_cool_health", 32'(health), 32'd85);
        ticks(70);
        player_hit_by_obstacle = 1'b0;
        chk("obs_100_health", 32'(health), 32'd70);
        chk("obs_combo", 32'(combo), 32'd0);

        // Pause freezes the cooldown while the obstacle is held
        new_session();
        player_hit_by_obstacle = 1'b1;
        tick();
        ticks(30);
        state = 2'd2;
        ticks(50);
        chk("pause_health", 32'(health), 32'd85);
        state = 2'd3;
        ticks(40);
        chk("pause3_health", 32'(health), 32'd85);
        state = 2'd1;
        ticks(29);
        chk("resume_early_health", 32'(health), 32'd85);
        ticks(3);
        chk("resume_hit_health", 32'(health), 32'd70);
        player_hit_by_obstacle = 1'b0;

        // Drain to 10 with misses, then slice plus obstacle ends the game
        new_session();
        block_missed = 1'b1;
        for (int i = 0; i < 9; i++) begin
            curr_block_index_in = 8'(100 + i);
            tick();
        end
        block_missed = 1'b0;
        chk("drain_health", 32'(health), 32'd10);
        chk("drain_game_over", 32'(game_over), 32'd0);
        curr_block_index_in = 8'd150;
        block_sliced = 1'b1;
        player_hit_by_obstacle = 1'b1;
        tick();
        block_sliced = 1'b0;
        player_hit_by_obstacle = 1'b0;
        chk("over_health", 32'(health), 32'd0);
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_score", 32'(score), 32'd100);
        chk("over_combo", 32'(combo), 32'd0);
        chk("over_mult", 32'(multiplier), 32'd1);
        curr_block_index_in = 8'd151;
        block_sliced = 1'b1;
        tick();
        block_sliced = 1'b0;
        chk("over_ignore_score", 32'(score), 32'd100);
        chk("over_ignore_event", 32'(score_event), 32'd0);
        chk("over_hold_flag", 32'(game_over), 32'd1);
        state = 2'd0;
        tick();
        chk("idle_flag", 32'(game_over), 32'd0);
        chk("idle_health_hold", 32'(health), 32'd0);
        state = 2'd1;
        tick();
        chk("restart_health", 32'(health), 32'd100);
        chk("restart_score", 32'(score), 32'd0);

        // Asynchronous reset mid-session, checked before the next edge
        curr_block_index_in = 8'd7;
        block_sliced = 1'b1;
        tick();
        block_sliced = 1'b0;
        chk("pre_rst_event", 32'(score_event), 32'd1);
        chk("pre_rst_score", 32'(score), 32'd100);
        #2;
        rst_in = 1'b1;
        #1;
        chk("async_score", 32'(score), 32'd0);
        chk("async_event", 32'(score_event), 32'd0);
        chk("async_mult", 32'(multiplier), 32'd1);
        chk("async_combo", 32'(combo), 32'd0);
        #1;
        rst_in = 1'b0;
        state = 2'd0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
